// File: rtl/mitch_dot_acc.sv
// Accumulates a programmed number of sign-magnitude-style products from the
// approximate multiplier into a wide signed sum, presented on a valid/ready port.
module mitch_dot_acc #(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             abort_i,
  output logic             busy_o,
  input  logic [31:0]      p_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [ACC_W-1:0] sum_o,
  output logic [LEN_W-1:0] count_o,
  output logic             ovf_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [LEN_W-1:0] count_reg, count_next;
  logic [LEN_W-1:0] remaining_reg, remaining_next;
  logic             ovf_reg, ovf_next;
  logic             in_ready_reg, out_valid_reg, busy_reg;

  // Multiplier negative results are one below the true two's-complement value.
  logic [31:0]      v32;
  logic [ACC_W-1:0] v_ext;
  logic [ACC_W-1:0] sum_w;
  logic             beat;

  assign v32 = p_i[31] ? (p_i + 32'd1) : p_i;
  assign v_ext[31:0] = v32;

  generate
    for (genvar gi = 32; gi < ACC_W; gi++) begin : g_sext
      assign v_ext[gi] = v32[31];
    end
  endgenerate

  assign sum_w = acc_reg + v_ext;
  assign beat  = in_valid_i & in_ready_reg;

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    count_next     = count_reg;
    remaining_next = remaining_reg;
    ovf_next       = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (!abort_i && start_i) begin
          acc_next       = '0;
          count_next     = '0;
          ovf_next       = 1'b0;
          remaining_next = len_i;
          state_next     = (len_i == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (abort_i) begin
          acc_next       = '0;
          count_next     = '0;
          ovf_next       = 1'b0;
          remaining_next = '0;
          state_next     = IDLE;
        end else if (beat) begin
          acc_next       = sum_w;
          count_next     = count_reg + LEN_W'(1);
          remaining_next = remaining_reg - LEN_W'(1);
          if ((acc_reg[ACC_W-1] == v_ext[ACC_W-1]) && (sum_w[ACC_W-1] != acc_reg[ACC_W-1]))
            ovf_next = 1'b1;
          if (remaining_reg == LEN_W'(1))
            state_next = DONE;
        end
      end
      DONE: begin
        if (abort_i) begin
          acc_next   = '0;
          count_next = '0;
          ovf_next   = 1'b0;
          state_next = IDLE;
        end else if (out_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they have no input path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      count_reg     <= '0;
      remaining_reg <= '0;
      ovf_reg       <= 1'b0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      count_reg     <= count_next;
      remaining_reg <= remaining_next;
      ovf_reg       <= ovf_next;
      in_ready_reg  <= (state_next == ACC);
      out_valid_reg <= (state_next == DONE);
      busy_reg      <= (state_next != IDLE);
    end
  end

  assign in_ready_o  = in_ready_reg;
  assign out_valid_o = out_valid_reg;
  assign busy_o      = busy_reg;
  assign sum_o       = acc_reg;
  assign count_o     = count_reg;
  assign ovf_o       = ovf_reg;

endmodule

// File: tb/tb_mitch_dot_acc.sv
// Directed bench for mitch_dot_acc: stimulus pushes expected results into a
// queue, and an output monitor pops and compares on every result handshake.
module tb_mitch_dot_acc;
  localparam int ACC_W = 34;
  localparam int LEN_W = 8;

  logic             clk, rst;
  logic             start_i, abort_i, in_valid_i, out_ready_i;
  logic [LEN_W-1:0] len_i;
  logic [31:0]      p_i;
  logic             busy_o, in_ready_o, ovf_o, out_valid_o;
  logic [ACC_W-1:0] sum_o;
  logic [LEN_W-1:0] count_o;

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic [LEN_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mitch_dot_acc #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i), .abort_i(abort_i),
    .busy_o(busy_o), .p_i(p_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .sum_o(sum_o), .count_o(count_o), .ovf_o(ovf_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: one comparison set per result handshake.
  always @(negedge clk) begin
    if (!rst && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum %0h count %0d with empty queue", sum_o, count_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_sum", 64'(sum_o), 64'(e.sum));
        check("result_count", 64'(count_o), 64'(e.cnt));
        check("result_ovf", 64'(ovf_o), 64'(e.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_vec(input logic [LEN_W-1:0] len);
    start_i = 1'b1;
    len_i   = len;
    tick();
    start_i = 1'b0;
    len_i   = 8'd99;
  endtask

  task automatic send_beat(input logic [31:0] p);
    int n;
    n = 0;
    in_valid_i = 1'b1;
    p_i        = p;
    while (!in_ready_o && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: in_ready_o stayed %0b, required 1", in_ready_o);
    end
    tick();
    in_valid_i = 1'b0;
    p_i        = 32'h0;
  endtask

  task automatic take_result(input logic [ACC_W-1:0] s, input logic [LEN_W-1:0] c, input logic o);
    exp_t e;
    e.sum = s;
    e.cnt = c;
    e.ovf = o;
    exp_q.push_back(e);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("idle_after_take", 64'({busy_o, out_valid_o}), 64'(0));
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; in_valid_i = 1'b0;
    out_ready_i = 1'b0; len_i = '0; p_i = '0;
    #1;
    check("reset_outputs", 64'({busy_o, in_ready_o, out_valid_o, ovf_o, count_o, sum_o}), 64'(0));
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: basic sum, valid one cycle after last handshake
    start_vec(8'd3);
    check("in_ready_in_acc", 64'(in_ready_o), 64'(1));
    send_beat(32'h00000006);
    send_beat(32'h00000010);
    send_beat(32'h00000100);
    check("valid_latency", 64'({out_valid_o, in_ready_o}), 64'(2'b10));
    take_result(34'd278, 8'd3, 1'b0);
    tick();

    // 2: sign conversion
    start_vec(8'd2);
    send_beat(32'h00000006);
    send_beat(32'hFFFFFFF9);
    take_result(34'd0, 8'd2, 1'b0);
    tick();
    start_vec(8'd1);
    send_beat(32'hFFFFFFFF);
    take_result(34'd0, 8'd1, 1'b0);
    tick();
    start_vec(8'd1);
    send_beat(32'hFFFFFFF0);
    take_result(34'h3_FFFF_FFF1, 8'd1, 1'b0);
    tick();

    // 3: flow control with gapped input and a stalled consumer
    begin
      logic [6:0] pat;
      logic [31:0] val;
      pat = 7'b1011001;
      val = 32'd1;
      start_vec(8'd4);
      for (int k = 0; k < 7; k++) begin
        in_valid_i = pat[k];
        p_i        = val;
        if (pat[k] && in_ready_o) val = val + 32'd1;
        tick();
      end
      in_valid_i = 1'b0;
      check("gapped_valid", 64'(out_valid_o), 64'(1));
      for (int k = 0; k < 5; k++) begin
        check("stall_hold", 64'({in_ready_o, out_valid_o, count_o, sum_o}),
              64'({1'b0, 1'b1, 8'd4, 34'd10}));
        tick();
      end
      take_result(34'd10, 8'd4, 1'b0);
      tick();
    end

    // 4: zero length goes straight to DONE
    start_vec(8'd0);
    check("zero_len", 64'({in_ready_o, out_valid_o, busy_o}), 64'(3'b011));
    take_result(34'd0, 8'd0, 1'b0);
    tick();

    // 5: overflow and its clearing on the next start
    start_vec(8'd5);
    for (int k = 0; k < 5; k++) send_beat(32'h7FFFFF00);
    take_result(34'h2_7FFF_FB00, 8'd5, 1'b1);
    tick();
    start_vec(8'd1);
    check("ovf_cleared_on_start", 64'(ovf_o), 64'(0));
    send_beat(32'h00000001);
    take_result(34'd1, 8'd1, 1'b0);
    tick();

    // 6a: abort mid-vector, beat on the abort cycle is dropped
    start_vec(8'd4);
    send_beat(32'h00000005);
    send_beat(32'h00000005);
    abort_i = 1'b1; in_valid_i = 1'b1; p_i = 32'h00000007;
    tick();
    abort_i = 1'b0; in_valid_i = 1'b0;
    check("abort_state", 64'({busy_o, in_ready_o, out_valid_o, count_o, sum_o}), 64'(0));
    for (int k = 0; k < 4; k++) begin
      tick();
      check("abort_no_valid", 64'(out_valid_o), 64'(0));
    end

    // 6b: asynchronous reset between edges
    start_vec(8'd3);
    send_beat(32'h00000009);
    #3 rst = 1'b1;
    #1;
    check("async_reset", 64'({busy_o, in_ready_o, out_valid_o, ovf_o, count_o, sum_o}), 64'(0));
    #2 rst = 1'b0;
    tick();

    // 6c: abort wins over start in IDLE
    start_i = 1'b1; abort_i = 1'b1; len_i = 8'd2;
    tick();
    start_i = 1'b0; abort_i = 1'b0;
    check("abort_beats_start", 64'({busy_o, in_ready_o}), 64'(0));
    tick();
    check("abort_beats_start_later", 64'({busy_o, out_valid_o}), 64'(0));

    // recovery vector after the disturbances
    start_vec(8'd2);
    send_beat(32'h00000003);
    send_beat(32'hFFFFFFFE);
    take_result(34'd2, 8'd2, 1'b0);
    tick(); tick();

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
